// File: rtl/legv8_pkg.sv
// Shared LEGv8 control-unit definitions: opcodes, ALU function codes, FSM states,
// ControlWord field offsets and status flag positions.
package legv8_pkg;

  localparam logic [63:0] PC_RESET = 64'h0;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_EOR = 5'b01100;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  typedef enum logic [2:0] {
    C_ALU_R, C_ALU_I, C_LDUR, C_STUR, C_CBZ, C_CBNZ, C_B, C_BAD
  } iclass_t;

  localparam int CW_SA    = 20;
  localparam int CW_SB    = 15;
  localparam int CW_DA    = 10;
  localparam int CW_RW    = 9;
  localparam int CW_MW    = 8;
  localparam int CW_FS    = 3;
  localparam int CW_BSEL  = 2;
  localparam int CW_ENMEM = 1;
  localparam int CW_ENALU = 0;

  localparam int ST_V = 3;
  localparam int ST_C = 2;
  localparam int ST_N = 1;
  localparam int ST_Z = 0;

endpackage

// File: rtl/legv8_decode.sv
// Combinational instruction decoder: classifies the IR and extracts register
// fields plus the extended immediates and pre-shifted branch offsets.
module legv8_decode
  import legv8_pkg::*;
(
  input  logic [31:0] instr_i,
  output iclass_t     cls_o,
  output logic [4:0]  fs_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rn_o,
  output logic [4:0]  rm_o,
  output logic [63:0] imm12_o,
  output logic [63:0] imm9_o,
  output logic [63:0] br19_o,
  output logic [63:0] br26_o
);

  assign rd_o    = instr_i[4:0];
  assign rn_o    = instr_i[9:5];
  assign rm_o    = instr_i[20:16];
  assign imm12_o = {52'h0, instr_i[21:10]};
  assign imm9_o  = {{55{instr_i[20]}}, instr_i[20:12]};
  assign br19_o  = {{43{instr_i[23]}}, instr_i[23:5], 2'b00};
  assign br26_o  = {{36{instr_i[25]}}, instr_i[25:0], 2'b00};

  always_comb begin
    cls_o = C_BAD;
    fs_o  = FS_ADD;
    if (instr_i[31:21] == OP_ADD) begin
      cls_o = C_ALU_R;
    end else if (instr_i[31:21] == OP_SUB) begin
      cls_o = C_ALU_R;
      fs_o  = FS_SUB;
    end else if (instr_i[31:21] == OP_AND) begin
      cls_o = C_ALU_R;
      fs_o  = FS_AND;
    end else if (instr_i[31:21] == OP_ORR) begin
      cls_o = C_ALU_R;
      fs_o  = FS_ORR;
    end else if (instr_i[31:21] == OP_EOR) begin
      cls_o = C_ALU_R;
      fs_o  = FS_EOR;
    end else if (instr_i[31:22] == OP_ADDI) begin
      cls_o = C_ALU_I;
    end else if (instr_i[31:22] == OP_SUBI) begin
      cls_o = C_ALU_I;
      fs_o  = FS_SUB;
    end else if (instr_i[31:21] == OP_LDUR) begin
      cls_o = C_LDUR;
    end else if (instr_i[31:21] == OP_STUR) begin
      cls_o = C_STUR;
    end else if (instr_i[31:24] == OP_CBZ) begin
      cls_o = C_CBZ;
    end else if (instr_i[31:24] == OP_CBNZ) begin
      cls_o = C_CBNZ;
    end else if (instr_i[31:26] == OP_B) begin
      cls_o = C_B;
    end
  end

endmodule

// File: rtl/control_unit_legv8.sv
// Multi-cycle LEGv8 control unit: FETCH/EXEC/MEM sequencing, PC/IR/IPC ownership
// and ControlWord/constant generation for the datapath.
module control_unit_legv8
  import legv8_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [3:0]  status,
  output logic [63:0] PC,
  output logic [24:0] ControlWord,
  output logic [63:0] constant,
  output logic        halted
);

  state_t      state_q;
  logic [63:0] pc_q;
  logic [63:0] ipc_q;
  logic [31:0] ir_q;
  logic        halted_q;

  iclass_t     cls;
  logic [4:0]  fs, rd, rn, rm;
  logic [63:0] imm12, imm9, br19, br26;
  logic        zero_flag;
  logic        unused_status;

  legv8_decode u_decode (
    .instr_i (ir_q),
    .cls_o   (cls),
    .fs_o    (fs),
    .rd_o    (rd),
    .rn_o    (rn),
    .rm_o    (rm),
    .imm12_o (imm12),
    .imm9_o  (imm9),
    .br19_o  (br19),
    .br26_o  (br26)
  );

  assign zero_flag     = status[ST_Z];
  assign unused_status = ^{status[ST_V], status[ST_C], status[ST_N]};
  assign PC            = pc_q;
  assign halted        = halted_q;

  // Reset forces FETCH, which zeroes the ControlWord without waiting for a clock,
  // so an in-flight store is cancelled asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      pc_q     <= PC_RESET;
      ipc_q    <= '0;
      ir_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          ir_q    <= instruction;
          ipc_q   <= pc_q;
          pc_q    <= pc_q + 64'd4;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          case (cls)
            C_LDUR, C_STUR: state_q <= S_MEM;
            C_CBZ: begin
              if (zero_flag) pc_q <= ipc_q + br19;
              state_q <= S_FETCH;
            end
            C_CBNZ: begin
              if (!zero_flag) pc_q <= ipc_q + br19;
              state_q <= S_FETCH;
            end
            C_B: begin
              pc_q    <= ipc_q + br26;
              state_q <= S_FETCH;
            end
            C_BAD: begin
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end
            default: state_q <= S_FETCH;
          endcase
        end
        S_MEM:   state_q <= S_FETCH;
        default: state_q <= S_HALT;
      endcase
    end
  end

  always_comb begin
    ControlWord = '0;
    constant    = '0;
    case (state_q)
      S_EXEC: begin
        case (cls)
          C_ALU_R: begin
            ControlWord[CW_SA +: 5] = rn;
            ControlWord[CW_SB +: 5] = rm;
            ControlWord[CW_DA +: 5] = rd;
            ControlWord[CW_RW]      = 1'b1;
            ControlWord[CW_FS +: 5] = fs;
            ControlWord[CW_ENALU]   = 1'b1;
          end
          C_ALU_I: begin
            ControlWord[CW_SA +: 5] = rn;
            ControlWord[CW_DA +: 5] = rd;
            ControlWord[CW_RW]      = 1'b1;
            ControlWord[CW_FS +: 5] = fs;
            ControlWord[CW_BSEL]    = 1'b1;
            ControlWord[CW_ENALU]   = 1'b1;
            constant                = imm12;
          end
          C_LDUR, C_STUR: begin
            ControlWord[CW_SA +: 5] = rn;
            ControlWord[CW_SB +: 5] = rd;
            ControlWord[CW_FS +: 5] = FS_ADD;
            ControlWord[CW_BSEL]    = 1'b1;
            constant                = imm9;
          end
          C_CBZ, C_CBNZ: begin
            ControlWord[CW_SA +: 5] = rd;
            ControlWord[CW_FS +: 5] = FS_ADD;
            ControlWord[CW_BSEL]    = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        // Address fields repeat EXEC so the memory address stays stable.
        ControlWord[CW_SA +: 5] = rn;
        ControlWord[CW_SB +: 5] = rd;
        ControlWord[CW_FS +: 5] = FS_ADD;
        ControlWord[CW_BSEL]    = 1'b1;
        constant                = imm9;
        if (cls == C_LDUR) begin
          ControlWord[CW_DA +: 5] = rd;
          ControlWord[CW_RW]      = 1'b1;
          ControlWord[CW_ENMEM]   = 1'b1;
        end else if (cls == C_STUR) begin
          ControlWord[CW_MW]      = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit_legv8.sv
// Scoreboard bench for control_unit_legv8: per-cycle expectations are queued with
// the status stimulus and compared at each falling clock edge.
module tb_control_unit_legv8;

  localparam logic [4:0] T_ADD = 5'b01000;
  localparam logic [4:0] T_SUB = 5'b01001;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic [3:0]  status;
  logic [63:0] PC;
  logic [24:0] ControlWord;
  logic [63:0] constant;
  logic        halted;

  logic [31:0] imem [0:31];

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    string       tag;
    logic [63:0] pc;
    logic [24:0] cw;
    logic [63:0] cnst;
    logic        hlt;
    logic [3:0]  st;
  } exp_t;

  exp_t sb_q[$];

  always #5 clock = ~clock;

  assign instruction = (PC < 64'd128) ? imem[PC[6:2]] : 32'h0;

  control_unit_legv8 dut (
    .clock       (clock),
    .reset       (reset),
    .instruction (instruction),
    .status      (status),
    .PC          (PC),
    .ControlWord (ControlWord),
    .constant    (constant),
    .halted      (halted)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [24:0] mk_cw(input logic [4:0] sa, input logic [4:0] sb,
                                        input logic [4:0] da, input logic rw, input logic mw,
                                        input logic [4:0] fs, input logic bsel,
                                        input logic enm, input logic enalu);
    return {sa, sb, da, rw, mw, fs, bsel, enm, enalu};
  endfunction

  function automatic logic [3:0] rnd_st();
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic push(input string tag, input logic [63:0] pc, input logic [24:0] cw,
                      input logic [63:0] cnst, input logic hlt, input logic [3:0] st);
    exp_t e;
    e.tag = tag; e.pc = pc; e.cw = cw; e.cnst = cnst; e.hlt = hlt; e.st = st;
    sb_q.push_back(e);
  endtask

  task automatic push_prefix(input logic z);
    push("ADD.F",  64'h00, 25'h0, 64'h0, 1'b0, rnd_st());
    push("ADD.E",  64'h04, mk_cw(1, 2, 3, 1, 0, T_ADD, 0, 0, 1), 64'h0, 1'b0, rnd_st());
    push("ADDI.F", 64'h04, 25'h0, 64'h0, 1'b0, rnd_st());
    push("ADDI.E", 64'h08, mk_cw(31, 0, 1, 1, 0, T_ADD, 1, 0, 1), 64'd5, 1'b0, rnd_st());
    push("LDUR.F", 64'h08, 25'h0, 64'h0, 1'b0, rnd_st());
    push("LDUR.E", 64'h0C, mk_cw(1, 2, 0, 0, 0, T_ADD, 1, 0, 0), 64'd8, 1'b0, rnd_st());
    push("LDUR.M", 64'h0C, mk_cw(1, 2, 2, 1, 0, T_ADD, 1, 1, 0), 64'd8, 1'b0, rnd_st());
    push("SUB.F",  64'h0C, 25'h0, 64'h0, 1'b0, rnd_st());
    push("SUB.E",  64'h10, mk_cw(5, 6, 4, 1, 0, T_SUB, 0, 0, 1), 64'h0, 1'b0, rnd_st());
    push("CBZ.F",  64'h10, 25'h0, 64'h0, 1'b0, rnd_st());
    push("CBZ.E",  64'h14, mk_cw(7, 0, 0, 0, 0, T_ADD, 1, 0, 0), 64'h0, 1'b0,
         {3'($urandom_range(0, 7)), z});
  endtask

  task automatic push_stur();
    push("STUR.F", 64'h1C, 25'h0, 64'h0, 1'b0, rnd_st());
    push("STUR.E", 64'h20, mk_cw(10, 9, 0, 0, 0, T_ADD, 1, 0, 0), 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, rnd_st());
    push("STUR.M", 64'h20, mk_cw(10, 9, 0, 0, 1, T_ADD, 1, 0, 0), 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, rnd_st());
  endtask

  task automatic run_sb();
    exp_t e;
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      status = e.st;
      check({e.tag, ".pc"}, PC, e.pc);
      check({e.tag, ".cw"}, {39'h0, ControlWord}, {39'h0, e.cw});
      check({e.tag, ".const"}, constant, e.cnst);
      check({e.tag, ".halted"}, {63'h0, halted}, {63'h0, e.hlt});
      $display("[TB] %s pc=%h cw=%h const=%h halted=%0d status=%h",
               e.tag, PC, ControlWord, constant, halted, e.st);
      if (sb_q.size() != 0) @(negedge clock);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".pc"}, PC, 64'h0);
    check({tag, ".cw"}, {39'h0, ControlWord}, 64'h0);
    check({tag, ".memwrite"}, {63'h0, ControlWord[8]}, 64'h0);
    check({tag, ".const"}, constant, 64'h0);
    check({tag, ".halted"}, {63'h0, halted}, 64'h0);
    $display("[TB] %s pc=%h cw=%h const=%h halted=%0d", tag, PC, ControlWord, constant, halted);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) imem[i] = 32'h0;
    imem[0] = 32'h8B020023;  // ADD  X3,X1,X2
    imem[1] = 32'h910017E1;  // ADDI X1,X31,#5
    imem[2] = 32'hF8408022;  // LDUR X2,[X1,#8]
    imem[3] = 32'hCB0600A4;  // SUB  X4,X5,X6
    imem[4] = 32'hB4000067;  // CBZ  X7,+3
    imem[5] = 32'h14000002;  // B    +2
    imem[7] = 32'hF81F8149;  // STUR X9,[X10,#-8]

    reset  = 1'b0;
    status = 4'h0;
    repeat (2) @(negedge clock);
    check_reset_state("por");
    reset = 1'b1;

    push_prefix(1'b1);
    push_stur();
    push("BAD.F", 64'h20, 25'h0, 64'h0, 1'b0, rnd_st());
    push("BAD.E", 64'h24, 25'h0, 64'h0, 1'b0, rnd_st());
    for (int i = 0; i < 20; i++) push($sformatf("HALT%0d", i), 64'h24, 25'h0, 64'h0, 1'b1, rnd_st());
    run_sb();

    #2 reset = 1'b0;
    #1 check_reset_state("halt_rst");
    @(negedge clock);
    reset = 1'b1;

    push_prefix(1'b0);
    push("B.F", 64'h14, 25'h0, 64'h0, 1'b0, rnd_st());
    push("B.E", 64'h18, 25'h0, 64'h0, 1'b0, rnd_st());
    push_stur();
    run_sb();

    #2 reset = 1'b0;
    #1 check_reset_state("mem_rst");
    @(negedge clock);
    reset = 1'b1;

    push("POST.F", 64'h00, 25'h0, 64'h0, 1'b0, rnd_st());
    push("POST.E", 64'h04, mk_cw(1, 2, 3, 1, 0, T_ADD, 0, 0, 1), 64'h0, 1'b0, rnd_st());
    run_sb();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
